kernel_scan_controller: RTL and testbench

Sequences the kernel neighbour-address operator over one image frame. On a start command it walks the centre-pixel address (width column, depth row) across the whole IMG_W x IMG_H grid, one address per accepted beat. Downstream flow control is a valid/ready handshake. With every address it outputs boundary flags, so downstream logic can suppress the wrapped left/right/top/bottom neighbours that 3-bit address arithmetic produces at the image edges.

---
 rtl/kernel_pkg.sv | 16 +
 rtl/kernel_scan_controller_if.sv | 40 ++++
 rtl/kernel_scan_counter.sv | 63 ++++++
 rtl/kernel_scan_controller.sv | 108 ++++++++++
 tb/tb_kernel_scan_controller.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kernel_pkg.sv
// Shared types and default geometry for the kernel scan controller.
// Optional build macro KSCAN_SERPENTINE_EN selects boustrophedon scan order.
package kernel_pkg;

   localparam int AW_DEF    = 3;
   localparam int DW_DEF    = 3;
   localparam int IMG_W_DEF = 8;
   localparam int IMG_H_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } kscan_state_t;

endpackage

// File: rtl/kernel_scan_controller_if.sv
// Address stream from the scan controller: valid/ready handshake plus centre
// address and geometric boundary flags.
interface kernel_scan_controller_if #(
   parameter int AW = 3,
   parameter int DW = 3
);
   logic          out_valid;
   logic          out_ready;
   logic [AW-1:0] address_width;
   logic [DW-1:0] address_depth;
   logic          left_edge;
   logic          right_edge;
   logic          top_edge;
   logic          bottom_edge;
   logic          last_pixel;

   modport master (
      output out_valid,
      output address_width,
      output address_depth,
      output left_edge,
      output right_edge,
      output top_edge,
      output bottom_edge,
      output last_pixel,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  address_width,
      input  address_depth,
      input  left_edge,
      input  right_edge,
      input  top_edge,
      input  bottom_edge,
      input  last_pixel,
      output out_ready
   );
endinterface

// File: rtl/kernel_scan_counter.sv
// Width/depth counter pair for the frame scan; dir=1 walks the column downward.
// With KSCAN_SERPENTINE_EN the column holds on a row step instead of returning to 0.
module kernel_scan_counter #(
   parameter int AW    = 3,
   parameter int DW    = 3,
   parameter int IMG_W = 8,
   parameter int IMG_H = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          advance,
   input  logic          dir,
   output logic [AW-1:0] addr_w,
   output logic [DW-1:0] addr_d,
   output logic          col_term,
   output logic          row_term
);

   localparam logic [AW-1:0] W_MAX = AW'(IMG_W - 1);
   localparam logic [DW-1:0] D_MAX = DW'(IMG_H - 1);

   logic [AW-1:0] width_q, width_d;
   logic [DW-1:0] depth_q, depth_d;

   // Terminal column depends on the direction of travel along the row.
   assign col_term = dir ? (width_q == '0) : (width_q == W_MAX);
   assign row_term = (depth_q == D_MAX);

   always_comb begin
      width_d = width_q;
      depth_d = depth_q;
      if (clear) begin
         width_d = '0;
         depth_d = '0;
      end else if (advance) begin
         if (!col_term) begin
            width_d = dir ? (width_q - 1'b1) : (width_q + 1'b1);
         end else if (!row_term) begin
            depth_d = depth_q + 1'b1;
`ifdef KSCAN_SERPENTINE_EN
            width_d = width_q;
`else
            width_d = '0;
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         width_q <= '0;
         depth_q <= '0;
      end else begin
         width_q <= width_d;
         depth_q <= depth_d;
      end
   end

   assign addr_w = width_q;
   assign addr_d = depth_q;

endmodule

// File: rtl/kernel_scan_controller.sv
// Frame scan sequencer: walks the centre-pixel address over the image, one per
// accepted beat, with edge flags. Build macro KSCAN_SERPENTINE_EN selects serpentine order.
module kernel_scan_controller
   import kernel_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DW    = DW_DEF,
   parameter int IMG_W = IMG_W_DEF,
   parameter int IMG_H = IMG_H_DEF
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic                      abort,
   output logic                      busy,
   output logic                      done,
   kernel_scan_controller_if.master  bus
);

   localparam logic [AW-1:0] W_MAX = AW'(IMG_W - 1);
   localparam logic [DW-1:0] D_MAX = DW'(IMG_H - 1);

   kscan_state_t  state_q, state_d;
   logic          cnt_clear;
   logic          cnt_advance;
   logic          cnt_dir;
   logic          col_term;
   logic          row_term;
   logic          last_addr;
   logic          xfer;
   logic [AW-1:0] addr_w;
   logic [DW-1:0] addr_d;

`ifdef KSCAN_SERPENTINE_EN
   assign cnt_dir = addr_d[0];
`else
   assign cnt_dir = 1'b0;
`endif

   kernel_scan_counter #(
      .AW    (AW),
      .DW    (DW),
      .IMG_W (IMG_W),
      .IMG_H (IMG_H)
   ) u_counter (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (cnt_clear),
      .advance  (cnt_advance),
      .dir      (cnt_dir),
      .addr_w   (addr_w),
      .addr_d   (addr_d),
      .col_term (col_term),
      .row_term (row_term)
   );

   assign last_addr = col_term & row_term;
   assign xfer      = bus.out_valid & bus.out_ready;

   // Counter is held clear everywhere except an active, non-aborted scan.
   always_comb begin
      state_d     = state_q;
      cnt_clear   = 1'b1;
      cnt_advance = 1'b0;
      case (state_q)
         IDLE: begin
            if (start && !abort) state_d = SCAN;
         end
         SCAN: begin
            if (abort) begin
               state_d = IDLE;
            end else begin
               cnt_clear = 1'b0;
               if (xfer) begin
                  cnt_advance = 1'b1;
                  if (last_addr) state_d = DONE;
               end
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   assign busy              = (state_q != IDLE);
   assign done              = (state_q == DONE);
   assign bus.out_valid     = (state_q == SCAN);
   assign bus.address_width = addr_w;
   assign bus.address_depth = addr_d;
   assign bus.left_edge     = (addr_w == '0);
   assign bus.right_edge    = (addr_w == W_MAX);
   assign bus.top_edge      = (addr_d == '0);
   assign bus.bottom_edge   = (addr_d == D_MAX);
   assign bus.last_pixel    = last_addr;

endmodule

// File: tb/tb_kernel_scan_controller.sv
// Self-checking bench for kernel_scan_controller: frame order derived from beat
// index arithmetic, randomized back-pressure and start noise.
module tb_kernel_scan_controller;
   import kernel_pkg::*;

   localparam int AW   = AW_DEF;
   localparam int DW   = DW_DEF;
   localparam int W    = IMG_W_DEF;
   localparam int H    = IMG_H_DEF;
   localparam int NPIX = W * H;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic abort = 1'b0;
   logic busy;
   logic done;

   int checks = 0;
   int errors = 0;

   kernel_scan_controller_if #(.AW(AW), .DW(DW)) bus ();

   kernel_scan_controller #(
      .AW    (AW),
      .DW    (DW),
      .IMG_W (W),
      .IMG_H (H)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .abort (abort),
      .busy  (busy),
      .done  (done),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete, required finish before 500000");
      $fatal(1, "watchdog expired");
   end

   // Beat k of a frame: row-major position, odd rows mirrored in serpentine mode.
   function automatic void model_addr(input int k, output int w, output int d);
      d = k / W;
      w = k % W;
`ifdef KSCAN_SERPENTINE_EN
      if ((d % 2) == 1) w = W - 1 - w;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // mode 0: ready always high; 1: random ready and start noise; 2: two-cycle stall at (3,2)
   task automatic test_frame(input int mode, input string tag);
      int beat, cyc_cnt, w, d, stall_cnt, last_cnt;
      logic [AW-1:0] ew;
      logic [DW-1:0] ed;
      logic [4:0] eflags, aflags;
      beat = 0; cyc_cnt = 0; stall_cnt = 0; last_cnt = 0;
      bus.out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      while (beat < NPIX && cyc_cnt < 20 * NPIX) begin
         model_addr(beat, w, d);
         ew = AW'(w);
         ed = DW'(d);
         eflags = {w == 0, w == W - 1, d == 0, d == H - 1, beat == NPIX - 1};
         aflags = {bus.left_edge, bus.right_edge, bus.top_edge, bus.bottom_edge, bus.last_pixel};
         checks++;
         if ({bus.out_valid, busy, done} !== 3'b110) begin
            errors++;
            $display("FAIL %s scan_status beat %0d: valid/busy/done=%b, required 110", tag, beat,
                     {bus.out_valid, busy, done});
         end
         checks++;
         if (bus.address_width !== ew || bus.address_depth !== ed) begin
            errors++;
            $display("FAIL %s address beat %0d: got (%0d,%0d), required (%0d,%0d)", tag, beat,
                     bus.address_width, bus.address_depth, w, d);
         end
         checks++;
         if (aflags !== eflags) begin
            errors++;
            $display("FAIL %s flags beat %0d at (%0d,%0d): L/R/T/B/last=%b, required %b", tag, beat,
                     w, d, aflags, eflags);
         end
         case (mode)
            0: bus.out_ready = 1'b1;
            1: bus.out_ready = ($urandom_range(0, 3) != 0);
            default: begin
               if (w == 3 && d == 2 && stall_cnt < 2) begin
                  bus.out_ready = 1'b0;
                  stall_cnt++;
               end else begin
                  bus.out_ready = 1'b1;
               end
            end
         endcase
         if (mode == 1) start = ($urandom_range(0, 7) == 0);
         if (bus.out_ready && bus.last_pixel === 1'b1) last_cnt++;
         if (bus.out_ready) beat++;
         step();
         cyc_cnt++;
      end
      start = 1'b0;
      checks++;
      if (beat != NPIX) begin
         errors++;
         $display("FAIL %s cycle_budget: %0d beats, required %0d", tag, beat, NPIX);
      end
      checks++;
      if ({done, busy, bus.out_valid} !== 3'b110) begin
         errors++;
         $display("FAIL %s done_pulse: done/busy/valid=%b, required 110", tag, {done, busy, bus.out_valid});
      end
      step();
      checks++;
      if ({done, busy, bus.out_valid} !== 3'b000) begin
         errors++;
         $display("FAIL %s idle_after_done: done/busy/valid=%b, required 000", tag, {done, busy, bus.out_valid});
      end
      checks++;
      if (bus.address_width !== '0 || bus.address_depth !== '0) begin
         errors++;
         $display("FAIL %s addr_cleared: got (%0d,%0d), required (0,0)", tag,
                  bus.address_width, bus.address_depth);
      end
      checks++;
      if (last_cnt != 1) begin
         errors++;
         $display("FAIL %s last_pixel_count: %0d, required 1", tag, last_cnt);
      end
      if (mode == 0) begin
         checks++;
         if (cyc_cnt != NPIX) begin
            errors++;
            $display("FAIL %s throughput: %0d cycles, required %0d", tag, cyc_cnt, NPIX);
         end
      end
      if (mode == 2) begin
         checks++;
         if (stall_cnt != 2) begin
            errors++;
            $display("FAIL %s stall_seen: %0d stall cycles, required 2", tag, stall_cnt);
         end
      end
      $display("%s: %0d beats in %0d cycles", tag, beat, cyc_cnt);
   endtask

   task automatic test_reset();
      bus.out_ready = 1'b0;
      #1;
      checks++;
      if ({busy, done, bus.out_valid} !== 3'b000 || bus.address_width !== '0 || bus.address_depth !== '0) begin
         errors++;
         $display("FAIL reset_state: busy/done/valid=%b addr=(%0d,%0d), required 000 (0,0)",
                  {busy, done, bus.out_valid}, bus.address_width, bus.address_depth);
      end
      step();
      step();
      rst_n = 1'b1;
      step();
      $display("reset: released");
   endtask

   task automatic test_full_frame();
      test_frame(0, "full_frame");
   endtask

   task automatic test_backpressure();
      test_frame(2, "stall_3_2");
      for (int i = 0; i < 3; i++) test_frame(1, "random_ready");
   endtask

   task automatic test_abort();
      int k, w, d;
      k = 0;
      for (int i = 0; i < NPIX; i++) begin
         model_addr(i, w, d);
         if (w == 5 && d == 3) k = i;
      end
      bus.out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < k; i++) step();
      checks++;
      if (bus.address_width !== AW'(5) || bus.address_depth !== DW'(3) || bus.out_valid !== 1'b1) begin
         errors++;
         $display("FAIL abort_target: got (%0d,%0d) valid=%b, required (5,3) valid=1",
                  bus.address_width, bus.address_depth, bus.out_valid);
      end
      abort = 1'b1;
      step();
      abort = 1'b0;
      checks++;
      if ({busy, done, bus.out_valid} !== 3'b000 || bus.address_width !== '0 || bus.address_depth !== '0) begin
         errors++;
         $display("FAIL abort_idle: busy/done/valid=%b addr=(%0d,%0d), required 000 (0,0)",
                  {busy, done, bus.out_valid}, bus.address_width, bus.address_depth);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done cycle %0d: done=%b busy=%b, required 0 0", i, done, busy);
         end
      end
      $display("abort: at beat %0d", k);
   endtask

   task automatic test_start_abort_idle();
      start = 1'b1;
      abort = 1'b1;
      step();
      start = 1'b0;
      abort = 1'b0;
      checks++;
      if ({busy, bus.out_valid} !== 2'b00) begin
         errors++;
         $display("FAIL start_abort_idle: busy/valid=%b, required 00", {busy, bus.out_valid});
      end
      step();
      checks++;
      if ({busy, bus.out_valid} !== 2'b00) begin
         errors++;
         $display("FAIL start_abort_idle_hold: busy/valid=%b, required 00", {busy, bus.out_valid});
      end
      $display("start_abort_idle: stayed idle");
   endtask

   task automatic test_reset_mid_scan();
      int w, d;
      bus.out_ready = 1'b1;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 20; i++) step();
      model_addr(20, w, d);
      checks++;
      if (bus.address_width !== AW'(w) || bus.address_depth !== DW'(d)) begin
         errors++;
         $display("FAIL mid_scan_addr: got (%0d,%0d), required (%0d,%0d)",
                  bus.address_width, bus.address_depth, w, d);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, done, bus.out_valid} !== 3'b000 || bus.address_width !== '0 || bus.address_depth !== '0) begin
         errors++;
         $display("FAIL mid_scan_reset: busy/done/valid=%b addr=(%0d,%0d), required 000 (0,0)",
                  {busy, done, bus.out_valid}, bus.address_width, bus.address_depth);
      end
      step();
      rst_n = 1'b1;
      step();
      $display("reset_mid_scan: reset at beat 20");
      test_frame(0, "rescan_after_reset");
   endtask

   task automatic test_back_to_back();
      test_frame(0, "back_to_back_a");
      test_frame(0, "back_to_back_b");
   endtask

   initial begin
      bus.out_ready = 1'b0;
      test_reset();
      test_full_frame();
      test_backpressure();
      test_abort();
      test_start_abort_idle();
      test_reset_mid_scan();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
